// File: rtl/uart_fifo_pkg.sv
// UART FIFO controller shared definitions.
// Register offsets, STATUS/CTRL bit indices, TX FSM states.
package uart_fifo_pkg;

  localparam logic [11:0] ADDR_STATUS = 12'h000;
  localparam logic [11:0] ADDR_DATA   = 12'h008;
  localparam logic [11:0] ADDR_CTRL   = 12'h010;

  localparam int ST_TX_FULL = 0;
  localparam int ST_RX_NE   = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_RX_OVR  = 3;
  localparam int ST_TX_DROP = 4;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two DEPTH.
// Ports: clk_sys, reset_n, push/wdata, pop, head, count, full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // count never exceeds 2**AW, so its MSB alone marks full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: MMIO register block with TX/RX byte FIFOs for a UART core.
// Ports: clk_i, reset_n, MMIO io_*, TX tx_*, RX rx_*, irq_o.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        io_read_valid_i,
  input  logic        io_write_valid_i,
  input  logic [11:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        irq_o
);

  localparam int TXW = $clog2(TX_DEPTH) + 1;
  localparam int RXW = $clog2(RX_DEPTH) + 1;

  logic [7:0]     tx_head;
  logic [TXW-1:0] tx_count;
  logic           tx_full;
  logic           tx_empty;
  logic           tx_push;
  logic           tx_pop;

  logic [7:0]     rx_head;
  logic [RXW-1:0] rx_count;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_push;
  logic           rx_pop;

  tx_state_t      state;
  logic           launch_cnt;
  logic [1:0]     ctrl;
  logic           rx_ovr;
  logic           tx_drop;
  logic           tx_idle;

  logic           data_wr;
  logic           stat_wr;
  logic           ctrl_wr;
  logic [31:0]    status;
  logic [31:0]    rdata_nxt;

  assign data_wr = io_write_valid_i && (io_addr_i == ADDR_DATA);
  assign stat_wr = io_write_valid_i && (io_addr_i == ADDR_STATUS);
  assign ctrl_wr = io_write_valid_i && (io_addr_i == ADDR_CTRL);

  assign tx_push = data_wr && !tx_full;
  assign tx_pop  = (state == TX_IDLE) && !tx_empty && !tx_busy_i;
  assign tx_idle = tx_empty && (state == TX_IDLE);

  // ready stays high through reset; the FIFO drops those bytes
  assign rx_ready_o = !reset_n || !rx_full;
  assign rx_push    = rx_valid_i && rx_ready_o;
  assign rx_pop     = io_read_valid_i && (io_addr_i == ADDR_DATA)
                      && !rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_sys (clk_i),
    .reset_n (reset_n),
    .push    (tx_push),
    .wdata   (io_wdata_i[7:0]),
    .pop     (tx_pop),
    .head    (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_sys (clk_i),
    .reset_n (reset_n),
    .push    (rx_push),
    .wdata   (rx_data_i),
    .pop     (rx_pop),
    .head    (rx_head),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    status             = '0;
    status[ST_TX_FULL] = tx_full;
    status[ST_RX_NE]   = !rx_empty;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_RX_OVR]  = rx_ovr;
    status[ST_TX_DROP] = tx_drop;
    // a count of 256 wraps to 0 here; full flag is authoritative
    status[15:8]       = 8'(rx_count);
    status[23:16]      = 8'(tx_count);
  end

  always_comb begin
    rdata_nxt = '0;
    case (io_addr_i)
      ADDR_STATUS: rdata_nxt = status;
      ADDR_DATA:   rdata_nxt = {!rx_empty, 23'h0,
                                rx_empty ? 8'h00 : rx_head};
      ADDR_CTRL:   rdata_nxt = {30'h0, ctrl};
      default:     rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      io_rdata_o <= '0;
      ctrl       <= '0;
      rx_ovr     <= 1'b0;
      tx_drop    <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      io_rdata_o <= rdata_nxt;
      if (ctrl_wr) ctrl <= io_wdata_i[1:0];
      // a new event wins over a same-cycle W1C
      rx_ovr  <= (rx_valid_i && rx_full) ||
                 (rx_ovr && !(stat_wr && io_wdata_i[ST_RX_OVR]));
      tx_drop <= (data_wr && tx_full) ||
                 (tx_drop && !(stat_wr && io_wdata_i[ST_TX_DROP]));
      irq_o   <= (ctrl[CTRL_RX_IE] && !rx_empty) ||
                 (ctrl[CTRL_TX_IE] && tx_idle);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state      <= TX_IDLE;
      launch_cnt <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      tx_valid_o <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= tx_head;
            launch_cnt <= 1'b0;
            state      <= TX_LAUNCH;
          end
        end
        TX_LAUNCH: begin
          // give the core two cycles to raise busy
          if (tx_busy_i)       state      <= TX_WAIT;
          else if (launch_cnt) state      <= TX_IDLE;
          else                 launch_cnt <= 1'b1;
        end
        TX_WAIT: begin
          if (!tx_busy_i) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench for uart_fifo_ctrl: scenario tasks, queue-based reference model.
// Drives MMIO, a UART core busy model and RX bytes; checks against the model.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam logic [11:0] A_STATUS = 12'h000;
  localparam logic [11:0] A_DATA   = 12'h008;
  localparam logic [11:0] A_CTRL   = 12'h010;

  logic        clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_read_valid_i = 1'b0;
  logic        io_write_valid_i = 1'b0;
  logic [11:0] io_addr_i = '0;
  logic [31:0] io_wdata_i = '0;
  logic [31:0] io_rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_busy_i;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  // 0: idle core, 1: busy forced high, 2: busy 10 cycles after strobe
  int busy_mode = 0;
  int busy_cnt  = 0;
  logic [7:0] seen_q[$];
  int busy_viol = 0;
  logic prev_v = 1'b0;

  always #5 clk_i = ~clk_i;

  assign tx_busy_i = (busy_mode == 1) ||
                     ((busy_mode == 2) && (busy_cnt != 0));

  always @(posedge clk_i) begin
    if (tx_valid_o) begin
      seen_q.push_back(tx_data_o);
      if (tx_busy_i || prev_v) busy_viol++;
    end
    prev_v <= tx_valid_o;
    if (tx_valid_o)         busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  uart_fifo_ctrl #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .reset_n          (reset_n),
    .io_read_valid_i  (io_read_valid_i),
    .io_write_valid_i (io_write_valid_i),
    .io_addr_i        (io_addr_i),
    .io_wdata_i       (io_wdata_i),
    .io_rdata_o       (io_rdata_o),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_busy_i        (tx_busy_i),
    .rx_data_i        (rx_data_i),
    .rx_valid_i       (rx_valid_i),
    .rx_ready_o       (rx_ready_o),
    .irq_o            (irq_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mmio_write(input logic [11:0] a, input logic [31:0] d);
    io_write_valid_i = 1'b1;
    io_addr_i = a;
    io_wdata_i = d;
    tick();
    io_write_valid_i = 1'b0;
  endtask

  task automatic mmio_read(input logic [11:0] a, output logic [31:0] d);
    io_read_valid_i = 1'b1;
    io_addr_i = a;
    tick();
    d = io_rdata_o;
    io_read_valid_i = 1'b0;
  endtask

  // register read without a strobe: no side effects
  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    io_addr_i = a;
    tick();
    d = io_rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i = 8'hAA;
    tick();
    tick();
    n_tests++;
    if (rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rx_ready got=%b exp=1", rx_ready_o);
    end
    n_tests++;
    if ({io_rdata_o, irq_o, tx_valid_o, tx_data_o} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdata=%h irq=%b v=%b d=%h exp=0",
               io_rdata_o, irq_o, tx_valid_o, tx_data_o);
    end
    rx_valid_i = 1'b0;
    reset_n = 1'b1;
    peek(A_STATUS, d);
    n_tests++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_status got=%h exp=%h", d, 32'h4);
    end
    peek(A_CTRL, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%h exp=0", d);
    end
  endtask

  task automatic test_tx_pair();
    busy_mode = 2;
    seen_q.delete();
    busy_viol = 0;
    mmio_write(A_DATA, 32'h41);
    mmio_write(A_DATA, 32'h42);
    for (int i = 0; i < 100 && seen_q.size() < 2; i++) tick();
    for (int i = 0; i < 20; i++) tick();
    n_tests++;
    if (seen_q.size() !== 2) begin
      n_fail++;
      $display("FAIL tx_pair_count got=%0d exp=2", seen_q.size());
    end
    n_tests++;
    if (seen_q.size() < 2 || seen_q[0] !== 8'h41 || seen_q[1] !== 8'h42)
    begin
      n_fail++;
      $display("FAIL tx_pair_bytes got=%p exp=41,42", seen_q);
    end
    n_tests++;
    if (busy_viol !== 0) begin
      n_fail++;
      $display("FAIL tx_pair_busy got=%0d exp=0", busy_viol);
    end
    n_tests++;
    if (tx_data_o !== 8'h42) begin
      n_fail++;
      $display("FAIL tx_data_hold got=%h exp=42", tx_data_o);
    end
    busy_mode = 0;
  endtask

  task automatic test_tx_overflow();
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic [31:0] d;
    logic        drop;
    int          n;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 17 : $urandom_range(1, 20);
      exp_q.delete();
      drop = 1'b0;
      busy_mode = 1;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        mmio_write(A_DATA, {24'($urandom), b});
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else drop = 1'b1;
      end
      peek(A_STATUS, d);
      n_tests++;
      if (d[0] !== (exp_q.size() == DEPTH) || d[4] !== drop ||
          d[23:16] !== 8'(exp_q.size()) || d[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_ovf_status n=%0d got=%h exp full=%b drop=%b cnt=%0d",
                 n, d, exp_q.size() == DEPTH, drop, exp_q.size());
      end
      mmio_write(A_STATUS, 32'h10);
      peek(A_STATUS, d);
      n_tests++;
      if (d[4] !== 1'b0 || d[23:16] !== 8'(exp_q.size())) begin
        n_fail++;
        $display("FAIL tx_drop_w1c got=%h exp drop=0 cnt=%0d",
                 d, exp_q.size());
      end
      seen_q.delete();
      busy_viol = 0;
      busy_mode = 2;
      for (int i = 0; i < 400 && seen_q.size() < exp_q.size(); i++) tick();
      for (int i = 0; i < 20; i++) tick();
      n_tests++;
      if (seen_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL tx_drain_count got=%0d exp=%0d",
                 seen_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
        n_tests++;
        if (seen_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL tx_drain_byte%0d got=%h exp=%h",
                   i, seen_q[i], exp_q[i]);
        end
      end
      n_tests++;
      if (busy_viol !== 0) begin
        n_fail++;
        $display("FAIL tx_drain_busy got=%0d exp=0", busy_viol);
      end
      busy_mode = 0;
    end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    rx_valid_i = 1'b1;
    rx_data_i = 8'h55;
    tick();
    rx_valid_i = 1'b0;
    mmio_read(A_DATA, d);
    n_tests++;
    if (d !== 32'h8000_0055) begin
      n_fail++;
      $display("FAIL rx_read1 got=%h exp=80000055", d);
    end
    mmio_read(A_DATA, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rx_read2 got=%h exp=0", d);
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      rx_valid_i = 1'b1;
      rx_data_i = b;
      tick();
      q.push_back(b);
    end
    rx_data_i = 8'hC3;
    #0;
    n_tests++;
    if (rx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_full_ready got=%b exp=0", rx_ready_o);
    end
    tick();
    peek(A_STATUS, d);
    n_tests++;
    if (d !== 32'h0000_100E) begin
      n_fail++;
      $display("FAIL rx_ovr_status got=%h exp=0000100e", d);
    end
    mmio_write(A_STATUS, 32'h08);
    peek(A_STATUS, d);
    n_tests++;
    if (d[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_ovr_setclr got=%b exp=1", d[3]);
    end
    mmio_read(A_DATA, d);
    e = {1'b1, 23'h0, q[0]};
    void'(q.pop_front());
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL rx_ovr_pop got=%h exp=%h", d, e);
    end
    n_tests++;
    if (rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_ready_after_pop got=%b exp=1", rx_ready_o);
    end
    tick();
    q.push_back(8'hC3);
    n_tests++;
    if (rx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_ready_refill got=%b exp=0", rx_ready_o);
    end
    rx_valid_i = 1'b0;
    mmio_write(A_STATUS, 32'h08);
    for (int i = 0; i <= DEPTH; i++) begin
      mmio_read(A_DATA, d);
      e = (q.size() != 0) ? {1'b1, 23'h0, q[0]} : 32'h0;
      if (q.size() != 0) void'(q.pop_front());
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL rx_ovr_drain%0d got=%h exp=%h", i, d, e);
      end
    end
    peek(A_STATUS, d);
    n_tests++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL rx_ovr_clear got=%h exp=4", d);
    end
  endtask

  task automatic test_rx_random();
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] e;
    logic [31:0] d;
    logic        rv;
    logic        rd;
    logic        ovr;
    logic        full_pre;
    ovr = 1'b0;
    io_addr_i = A_DATA;
    for (int c = 0; c < 300; c++) begin
      rv = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 2) == 0);
      b = 8'($urandom);
      rx_valid_i = rv;
      rx_data_i = b;
      io_read_valid_i = rd;
      full_pre = (q.size() == DEPTH);
      e = (q.size() != 0) ? {1'b1, 23'h0, q[0]} : 32'h0;
      #0;
      n_tests++;
      if (rx_ready_o !== !full_pre) begin
        n_fail++;
        $display("FAIL rx_rand_ready c=%0d got=%b exp=%b",
                 c, rx_ready_o, !full_pre);
      end
      tick();
      if (rd) begin
        n_tests++;
        if (io_rdata_o !== e) begin
          n_fail++;
          $display("FAIL rx_rand_read c=%0d got=%h exp=%h",
                   c, io_rdata_o, e);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (rv && !full_pre) q.push_back(b);
      if (rv && full_pre) ovr = 1'b1;
    end
    rx_valid_i = 1'b0;
    io_read_valid_i = 1'b0;
    peek(A_STATUS, d);
    n_tests++;
    if (d[1] !== (q.size() != 0) || d[3] !== ovr ||
        d[15:8] !== 8'(q.size())) begin
      n_fail++;
      $display("FAIL rx_rand_status got=%h exp ne=%b ovr=%b cnt=%0d",
               d, q.size() != 0, ovr, q.size());
    end
    while (q.size() != 0) begin
      mmio_read(A_DATA, d);
      e = {1'b1, 23'h0, q.pop_front()};
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL rx_rand_drain got=%h exp=%h", d, e);
      end
    end
    mmio_write(A_STATUS, 32'h18);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    mmio_write(A_CTRL, 32'h1);
    peek(A_CTRL, d);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL ctrl_readback got=%h exp=1", d);
    end
    rx_valid_i = 1'b1;
    rx_data_i = 8'h5A;
    tick();
    rx_valid_i = 1'b0;
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_push_edge got=%b exp=0", irq_o);
    end
    tick();
    n_tests++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise got=%b exp=1", irq_o);
    end
    mmio_read(A_DATA, d);
    n_tests++;
    if (d !== 32'h8000_005A || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_pop got data=%h irq=%b exp 8000005a,1", d, irq_o);
    end
    tick();
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_fall got=%b exp=0", irq_o);
    end
    mmio_write(A_CTRL, 32'h3);
    tick();
    n_tests++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_tx_idle got=%b exp=1", irq_o);
    end
  endtask

  task automatic test_reset_midtx();
    logic [31:0] d;
    int          pulses;
    busy_mode = 2;
    for (int i = 0; i < 4; i++) mmio_write(A_DATA, 32'h60 + i);
    for (int i = 0; i < 50 && !tx_busy_i; i++) tick();
    tick();
    tick();
    peek(A_STATUS, d);
    n_tests++;
    if (d[23:16] !== 8'd3 || d[2] !== 1'b0 || tx_busy_i !== 1'b1) begin
      n_fail++;
      $display("FAIL midtx_pre got=%h busy=%b exp cnt=3 idle=0 busy=1",
               d, tx_busy_i);
    end
    pulses = seen_q.size();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    peek(A_STATUS, d);
    n_tests++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL midtx_status got=%h exp=4", d);
    end
    peek(A_CTRL, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL midtx_ctrl got=%h exp=0", d);
    end
    for (int i = 0; i < 30; i++) tick();
    n_tests++;
    if (seen_q.size() !== pulses) begin
      n_fail++;
      $display("FAIL midtx_pulses got=%0d exp=%0d", seen_q.size(), pulses);
    end
    busy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_tx_pair();
    test_tx_overflow();
    test_rx_basic();
    test_rx_overrun();
    test_rx_random();
    test_irq();
    test_reset_midtx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
